// File: rtl/furv_pkg.sv
// rtl/furv_pkg.sv - shared core constants and address helpers
package furv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned INSN_BYTES = 4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Instruction addresses are always word aligned; low byte-offset bits are dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(INSN_BYTES - 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - in-order word buffer with push/pop/flush and occupancy count
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !flush_i;

  // Pointer and occupancy next-state; flush empties the buffer outright.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless while count is zero, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - sequential instruction prefetch queue with redirect flush
module fetch_queue
  import furv_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc,
  input  logic            consume,
  output logic [XLEN-1:0] instruction,
  output logic            instr_valid,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata
);

  localparam int unsigned     CW        = $clog2(DEPTH + 1);
  localparam logic [CW:0]     DEPTH_L   = (CW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] STEP      = XLEN'(INSN_BYTES);
  localparam logic [XLEN-1:0] ADDR_MASK = ~(STEP - 1'b1);

  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [XLEN-1:0] ehead_q, ehead_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;

  logic [CW-1:0]   count;
  logic [XLEN-1:0] head_word;
  logic [CW:0]     inflight;
  logic            redirect;
  logic            grant;
  logic            pop;
  logic            push;

  // The core has left the predicted stream whenever its word address differs
  // from the address expected at the queue head.
  assign redirect = ((pc ^ ehead_q) & ADDR_MASK) != '0;

  // Buffered plus in-flight words may never exceed the queue capacity, so a
  // returning word always has a slot waiting for it.
  assign inflight = {1'b0, count} + {1'b0, outstanding_q};

  assign imem_req    = rst_n && !redirect && (inflight < DEPTH_L);
  assign imem_addr   = fpc_q;
  assign grant       = imem_req && imem_gnt;

  assign instr_valid = (count != '0) && !redirect;
  assign instruction = instr_valid ? head_word : '0;
  assign pop         = consume && instr_valid;

  // A word landing during a redirect, or while stale words remain, is dropped.
  assign push = imem_rvalid && !redirect && (discard_q == '0);

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect),
    .push_i  (push),
    .data_i  (imem_rdata),
    .pop_i   (pop),
    .data_o  (head_word),
    .count_o (count)
  );

  // Fetch pointer, expected-head address and in-flight bookkeeping.
  always_comb begin
    fpc_d         = fpc_q;
    ehead_d       = ehead_q;
    outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid);
    discard_d     = discard_q;

    if (redirect) begin
      fpc_d   = word_align(pc);
      ehead_d = word_align(pc);
      // Every word still owed by memory belongs to the abandoned stream. Words
      // already marked for discard are a subset of outstanding, so the new
      // drop count is simply what remains outstanding after this cycle.
      discard_d = outstanding_q - CW'(imem_rvalid);
    end else begin
      if (grant) begin
        fpc_d = fpc_q + STEP;
      end
      if (pop) begin
        ehead_d = ehead_q + STEP;
      end
      if (imem_rvalid && (discard_q != '0)) begin
        discard_d = discard_q - CW'(1);
      end
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fpc_q         <= RESET_PC;
      ehead_q       <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fpc_q         <= fpc_d;
      ehead_q       <= ehead_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue with pipelined memory model
module tb_fetch_queue;
  import furv_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc = 32'h0;
  logic        consume = 1'b0;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;

  int n_vec = 0;
  int n_err = 0;
  int delivered = 0;

  logic [31:0] exp_q[$];
  logic [31:0] pend[$];
  logic [31:0] gnt_log[$];
  bit          resp_en = 1'b1;
  bit          resp_s = 1'b0;
  bit          fire_s = 1'b0;
  logic [31:0] fire_addr = 32'h0;
  bit          bump = 1'b0;
  bit          sb_en = 1'b0;

  always #5 clk = ~clk;

  fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .consume     (consume),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Sample the request handshake mid-cycle.
  always @(negedge clk) begin
    fire_s    = rst_n && imem_req && imem_gnt;
    fire_addr = imem_addr;
    resp_s    = resp_en;
    if (fire_s) gnt_log.push_back(imem_addr);
  end

  // In-order memory: earliest response is the cycle after the grant.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      pend.delete();
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end else begin
      if (fire_s) pend.push_back(fire_addr);
      if (resp_s && pend.size() > 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
      end
    end
  end

  // Scoreboard: every valid word must match the word expected at the current pc.
  always @(negedge clk) begin
    if (rst_n && sb_en && instr_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_word: got %h at pc %h, required no valid word", instruction, pc);
      end else begin
        if (instruction !== exp_q[0]) begin
          n_err++;
          $display("FAIL sb_word: pc %h got %h required %h", pc, instruction, exp_q[0]);
        end
        if (consume) begin
          void'(exp_q.pop_front());
          delivered++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
    consume = 1'b0;
    if (bump) begin
      pc = pc + 32'd4;
      exp_q.push_back(mem_word(pc));
      bump = 1'b0;
    end
  endtask

  task automatic redirect_to(input logic [31:0] a);
    pc = a;
    exp_q.delete();
    exp_q.push_back(mem_word(a));
    delivered = 0;
  endtask

  task automatic run_consume(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      step();
      #1;
      if (instr_valid) begin
        consume = 1'b1;
        bump    = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    sb_en   = 1'b0;
    bump    = 1'b0;
    rst_n   = 1'b0;
    pc      = 32'h0;
    consume = 1'b0;
    imem_gnt = 1'b1;
    resp_en = 1'b1;
    exp_q.delete();
    repeat (3) step();
    #1;
  endtask

  task automatic start_release();
    step();
    rst_n = 1'b1;
    redirect_to(pc);
    sb_en = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b required 0", imem_req); end
    n_vec++;
    if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b required 0", instr_valid); end
    n_vec++;
    if (instruction !== 32'h0) begin n_err++; $display("FAIL reset_insn: got %h required 0", instruction); end
    n_vec++;
    if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h required 0", imem_addr); end
  endtask

  task automatic test_sequential();
    start_release();
    #1;
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_err++; $display("FAIL seq_c0: req %b addr %h required 1 / 00000000", imem_req, imem_addr);
    end
    step(); #1;
    n_vec++;
    if (instr_valid !== 1'b0 || imem_addr !== 32'h4) begin
      n_err++; $display("FAIL seq_c1: valid %b addr %h required 0 / 00000004", instr_valid, imem_addr);
    end
    step(); #1;
    n_vec++;
    if (instr_valid !== 1'b1) begin
      n_err++; $display("FAIL seq_c2_valid: got %b required 1", instr_valid);
    end
    if (instr_valid) begin consume = 1'b1; bump = 1'b1; end
    run_consume(30);
    step(); #1;
    n_vec++;
    if (delivered !== 31) begin
      n_err++; $display("FAIL seq_throughput: delivered %0d required 31", delivered);
    end
  endtask

  task automatic test_stall_full();
    step();
    imem_gnt = 1'b0;
    redirect_to(32'h40);
    #1;
    n_vec++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      n_err++; $display("FAIL stall_redirect: req %b valid %b required 0 / 0", imem_req, instr_valid);
    end
    for (int i = 0; i < 5; i++) begin
      step(); #1;
      n_vec++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
        n_err++; $display("FAIL stall_hold[%0d]: req %b addr %h required 1 / 00000040", i, imem_req, imem_addr);
      end
    end
    gnt_log.delete();
    imem_gnt = 1'b1;
    repeat (8) step();
    #1;
    n_vec++;
    if (gnt_log.size() !== 4) begin
      n_err++; $display("FAIL full_grants: got %0d grants required 4", gnt_log.size());
    end
    n_vec++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h50) begin
      n_err++; $display("FAIL full_req: req %b addr %h required 0 / 00000050", imem_req, imem_addr);
    end
    n_vec++;
    if (instr_valid !== 1'b1 || instruction !== mem_word(32'h40)) begin
      n_err++; $display("FAIL full_head: valid %b insn %h required 1 / %h", instr_valid, instruction, mem_word(32'h40));
    end
    if (instr_valid) begin consume = 1'b1; bump = 1'b1; end
    run_consume(11);
    step(); #1;
    n_vec++;
    if (delivered !== 12) begin
      n_err++; $display("FAIL full_resume: delivered %0d required 12", delivered);
    end
    n_vec++;
    if (gnt_log.size() < 5 || gnt_log[4] !== 32'h50) begin
      n_err++; $display("FAIL full_resume_addr: %0d grants, required fifth grant at 00000050", gnt_log.size());
    end
  endtask

  task automatic test_redirect();
    do_reset();
    start_release();
    resp_en = 1'b0;
    #1;
    step(); #1;
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      n_err++; $display("FAIL redir_c1: req %b addr %h required 1 / 00000004", imem_req, imem_addr);
    end
    step();
    imem_gnt = 1'b0;
    resp_en  = 1'b1;
    #1;
    n_vec++;
    if (imem_addr !== 32'h8) begin
      n_err++; $display("FAIL redir_c2: addr %h required 00000008", imem_addr);
    end
    step();
    imem_gnt = 1'b1;
    redirect_to(32'h100);
    #1;
    n_vec++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      n_err++; $display("FAIL redir_cycle: req %b valid %b required 0 / 0", imem_req, instr_valid);
    end
    step(); #1;
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_err++; $display("FAIL redir_refetch: req %b addr %h required 1 / 00000100", imem_req, imem_addr);
    end
    step(); #1;
    n_vec++;
    if (instr_valid !== 1'b0) begin
      n_err++; $display("FAIL redir_drop: valid %b insn %h required 0", instr_valid, instruction);
    end
    step(); #1;
    n_vec++;
    if (instr_valid !== 1'b1 || instruction !== mem_word(32'h100)) begin
      n_err++; $display("FAIL redir_first: valid %b insn %h required 1 / %h", instr_valid, instruction, mem_word(32'h100));
    end
    if (instr_valid) begin consume = 1'b1; bump = 1'b1; end
    run_consume(8);
    step(); #1;
    n_vec++;
    if (delivered !== 9) begin
      n_err++; $display("FAIL redir_stream: delivered %0d required 9", delivered);
    end
  endtask

  task automatic test_wrap();
    step();
    gnt_log.delete();
    redirect_to(32'hFFFF_FFF8);
    run_consume(10);
    step(); #1;
    n_vec++;
    if (gnt_log.size() < 3) begin
      n_err++; $display("FAIL wrap_grants: got %0d grants required at least 3", gnt_log.size());
    end else if (gnt_log[0] !== 32'hFFFF_FFF8 || gnt_log[1] !== 32'hFFFF_FFFC || gnt_log[2] !== 32'h0) begin
      n_err++; $display("FAIL wrap_addrs: got %h %h %h required fffffff8 fffffffc 00000000", gnt_log[0], gnt_log[1], gnt_log[2]);
    end
    n_vec++;
    if (delivered !== 8) begin
      n_err++; $display("FAIL wrap_stream: delivered %0d required 8", delivered);
    end
  endtask

  task automatic test_reset_mid();
    step();
    sb_en = 1'b0;
    bump  = 1'b0;
    rst_n = 1'b0;
    pc    = 32'h0;
    step(); #1;
    n_vec++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instruction !== 32'h0 || imem_addr !== 32'h0) begin
      n_err++; $display("FAIL midreset_state: req %b valid %b insn %h addr %h required 0 0 0 0",
                        imem_req, instr_valid, instruction, imem_addr);
    end
    start_release();
    step(); step(); #1;
    n_vec++;
    if (instr_valid !== 1'b1 || instruction !== mem_word(32'h0)) begin
      n_err++; $display("FAIL midreset_first: valid %b insn %h required 1 / %h", instr_valid, instruction, mem_word(32'h0));
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall_full();
    test_redirect();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
